// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with phase tracking,
// producing registered sync, data-enable, a one-cycle-early pixel fetch
// strobe with its coordinates, aligned RGB data and a frame-start pulse.
module video_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        clk_en,
  input  logic [23:0] pix_data,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // Phase encoding shared by the horizontal and vertical trackers
  localparam logic [1:0] PH_SYNC   = 2'd0;
  localparam logic [1:0] PH_BACK   = 2'd1;
  localparam logic [1:0] PH_ACTIVE = 2'd2;
  localparam logic [1:0] PH_FRONT  = 2'd3;

  // Counter values at which each phase begins
  localparam logic [9:0] H_BACK_AT  = 10'(H_SYNC);
  localparam logic [9:0] H_ACT_AT   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_FRONT_AT = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_BACK_AT  = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_AT   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_FRONT_AT = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [1:0]  h_ph_q, h_ph_d;
  logic [1:0]  v_ph_q, v_ph_d;
  logic        h_wrap;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        pix_req_q, pix_req_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [23:0] rgb_q, rgb_d;
  logic        fs_q, fs_d;

  // Counter advance and phase transitions at the programmed boundaries
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end

    h_ph_d = h_ph_q;
    if (h_cnt_d == 10'd0)            h_ph_d = PH_SYNC;
    else if (h_cnt_d == H_BACK_AT)   h_ph_d = PH_BACK;
    else if (h_cnt_d == H_ACT_AT)    h_ph_d = PH_ACTIVE;
    else if (h_cnt_d == H_FRONT_AT)  h_ph_d = PH_FRONT;

    v_ph_d = v_ph_q;
    if (h_wrap) begin
      if (v_cnt_d == 10'd0)            v_ph_d = PH_SYNC;
      else if (v_cnt_d == V_BACK_AT)   v_ph_d = PH_BACK;
      else if (v_cnt_d == V_ACT_AT)    v_ph_d = PH_ACTIVE;
      else if (v_cnt_d == V_FRONT_AT)  v_ph_d = PH_FRONT;
    end
  end

  // Output decode from the current count; registered so outputs lag by one clock
  always_comb begin
    hsync_d = (h_ph_q != PH_SYNC);
    vsync_d = (v_ph_q != PH_SYNC);
    de_d    = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
    // Fetch when the next count lands in the active window; a line wrap
    // always lands in SYNC, so the current row is the row being fetched.
    pix_req_d = (h_ph_d == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    if (pix_req_d) begin
      pix_x_d = h_cnt_d - H_ACT_AT;
      pix_y_d = v_cnt_q - V_ACT_AT;
    end
    // Data requested last clock is captured as de rises for that pixel
    rgb_d = pix_req_q ? pix_data : 24'h0;
    fs_d  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  // State update: reset dominates, clk_en low freezes everything
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      h_ph_q    <= PH_SYNC;
      v_ph_q    <= PH_SYNC;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b0;
      pix_req_q <= 1'b0;
      pix_x_q   <= 10'd0;
      pix_y_q   <= 10'd0;
      rgb_q     <= 24'h0;
      fs_q      <= 1'b0;
    end else if (clk_en) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_ph_q    <= h_ph_d;
      v_ph_q    <= v_ph_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      pix_req_q <= pix_req_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule
